// File: rtl/keypad_encoder_pkg.sv
// Shared definitions for the front-panel key encoder: FSM state encoding and
// an elaboration-time clog2 used to size the debounce counter.
package keypad_encoder_pkg;

  typedef logic [1:0] state_t;

  localparam state_t ST_IDLE         = 2'd0;
  localparam state_t ST_DEBOUNCE     = 2'd1;
  localparam state_t ST_REPORT       = 2'd2;
  localparam state_t ST_WAIT_RELEASE = 2'd3;

  function automatic int clog2(input int value);
    int v;
    int r;
    v = value - 1;
    r = 0;
    while (v > 0) begin
      r++;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/keypad_encoder_key_sync.sv
// Parametric-width two-flop synchroniser for asynchronous panel inputs.
module key_sync #(
  parameter int WIDTH = 1
) (
  input  logic             CLK,
  input  logic             RST_N,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] r_meta;
  logic [WIDTH-1:0] r_sync;

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_meta <= '0;
      r_sync <= '0;
    end else begin
      r_meta <= d;
      r_sync <= r_meta;
    end
  end

  assign q = r_sync;

endmodule

// File: rtl/keypad_encoder.sv
// Debounced single-key encoder with VALID/ACK handshake: one report per press,
// multi-key presses flagged on MULTI and never reported.
module keypad_encoder
  import keypad_encoder_pkg::*;
#(
  parameter int N_KEYS          = 10,
  parameter int CODE_W          = 4,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              CLK,
  input  logic              RST_N,
  input  logic [N_KEYS-1:0] KEYS,
  input  logic              EN,
  input  logic              ACK,
  output logic [CODE_W-1:0] CODE,
  output logic              DATA_VALID,
  output logic              MULTI
);

  localparam int CNT_W = (clog2(DEBOUNCE_CYCLES + 1) < 1) ? 1 : clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0]  CNT_MAX  = CNT_W'(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0]  CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  CNT_ONE  = CNT_W'(1);
  localparam logic [N_KEYS-1:0] KEY_ONE  = N_KEYS'(1);

  function automatic logic f_is_onehot(input logic [N_KEYS-1:0] v);
    return (v != '0) && ((v & (v - KEY_ONE)) == '0);
  endfunction

  function automatic logic f_is_multi(input logic [N_KEYS-1:0] v);
    return (v & (v - KEY_ONE)) != '0;
  endfunction

  function automatic logic [CODE_W-1:0] f_key_index(input logic [N_KEYS-1:0] v);
    logic [CODE_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      if (v[i]) idx = CODE_W'(i);
    end
    return idx;
  endfunction

  function automatic logic [CNT_W-1:0] f_sat_inc(input logic [CNT_W-1:0] c);
    return (c >= CNT_MAX) ? c : c + CNT_ONE;
  endfunction

  logic [N_KEYS-1:0] w_ks;
  logic              w_onehot;
  logic              w_multi_key;
  logic [CODE_W-1:0] w_idx;

  state_t            r_state,  w_state_nxt;
  logic [CNT_W-1:0]  r_cnt,    w_cnt_nxt;
  logic [CODE_W-1:0] r_cand,   w_cand_nxt;
  logic [CODE_W-1:0] r_code,   w_code_nxt;
  logic              r_valid,  w_valid_nxt;
  logic              r_multi,  w_multi_nxt;

  key_sync #(.WIDTH(N_KEYS)) u_key_sync (
    .CLK   (CLK),
    .RST_N (RST_N),
    .d     (KEYS),
    .q     (w_ks)
  );

  assign w_onehot    = f_is_onehot(w_ks);
  assign w_multi_key = f_is_multi(w_ks);
  assign w_idx       = f_key_index(w_ks);

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_cand_nxt  = r_cand;
    w_code_nxt  = r_code;
    w_valid_nxt = r_valid;
    w_multi_nxt = r_multi;
    // A pending report is always delivered, so EN only gates the other states.
    if (!EN && (r_state != ST_REPORT)) begin
      w_state_nxt = ST_IDLE;
      w_cnt_nxt   = '0;
      w_multi_nxt = 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_onehot) begin
            w_cand_nxt = w_idx;
            if (DEBOUNCE_CYCLES == 1) begin
              w_code_nxt  = w_idx;
              w_valid_nxt = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = ST_REPORT;
            end else begin
              w_cnt_nxt   = CNT_ONE;
              w_state_nxt = ST_DEBOUNCE;
            end
          end else if (w_multi_key) begin
            w_multi_nxt = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_WAIT_RELEASE;
          end
        end
        ST_DEBOUNCE: begin
          if (w_ks == '0) begin
            w_cnt_nxt   = '0;
            w_state_nxt = ST_IDLE;
          end else if (w_multi_key) begin
            w_multi_nxt = 1'b1;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_WAIT_RELEASE;
          end else if (w_idx == r_cand) begin
            if (r_cnt >= CNT_LAST) begin
              w_code_nxt  = r_cand;
              w_valid_nxt = 1'b1;
              w_cnt_nxt   = '0;
              w_state_nxt = ST_REPORT;
            end else begin
              w_cnt_nxt = f_sat_inc(r_cnt);
            end
          end else begin
            w_cand_nxt = w_idx;
            w_cnt_nxt  = CNT_ONE;
          end
        end
        ST_REPORT: begin
          if (ACK) begin
            w_valid_nxt = 1'b0;
            w_cnt_nxt   = '0;
            w_state_nxt = ST_WAIT_RELEASE;
          end
        end
        ST_WAIT_RELEASE: begin
          // Counting zero samples here is what blocks auto-repeat of a held key.
          if (w_ks != '0) begin
            w_cnt_nxt = '0;
          end else if (r_cnt >= CNT_LAST) begin
            w_cnt_nxt   = '0;
            w_multi_nxt = 1'b0;
            w_state_nxt = ST_IDLE;
          end else begin
            w_cnt_nxt = f_sat_inc(r_cnt);
          end
        end
        default: begin
          w_state_nxt = ST_IDLE;
          w_cnt_nxt   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_cand  <= '0;
      r_code  <= '0;
      r_valid <= 1'b0;
      r_multi <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_cand  <= w_cand_nxt;
      r_code  <= w_code_nxt;
      r_valid <= w_valid_nxt;
      r_multi <= w_multi_nxt;
    end
  end

  assign CODE       = r_code;
  assign DATA_VALID = r_valid;
  assign MULTI      = r_multi;

endmodule
